// File: rtl/zeroheti_obi_apb_bridge.sv
// ----------------------------------------------------------------------------
// zeroheti_obi_apb_bridge
//
// OBI subordinate that turns each granted OBI transaction into a single APB4
// transfer and returns the APB completion as a one-cycle OBI response. Only one
// transaction is in flight at a time. An optional PREADY timeout converts a
// hung peripheral into an OBI error response.
//
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   obi_req_i / obi_gnt_o   : OBI request / grant (grant is combinational)
//   obi_addr_i, obi_we_i,
//   obi_be_i, obi_wdata_i   : OBI request payload
//   obi_rvalid_o,
//   obi_rdata_o, obi_err_o  : OBI response (data/err are 0 when rvalid is 0)
//   paddr_o .. pprot_o      : APB4 requester outputs (registered)
//   pready_i, prdata_i,
//   pslverr_i               : APB4 completer inputs
// ----------------------------------------------------------------------------
module zeroheti_obi_apb_bridge #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [AddrWidth-1:0] obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [3:0]           obi_be_i,
    input  logic [DataWidth-1:0] obi_wdata_i,
    output logic                 obi_rvalid_o,
    output logic [DataWidth-1:0] obi_rdata_o,
    output logic                 obi_err_o,
    output logic [AddrWidth-1:0] paddr_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [DataWidth-1:0] pwdata_o,
    output logic [3:0]           pstrb_o,
    output logic [2:0]           pprot_o,
    input  logic                 pready_i,
    input  logic [DataWidth-1:0] prdata_i,
    input  logic                 pslverr_i
);

    // Counter must hold values 0..TimeoutCycles; keep at least one bit.
    localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast =
        CntW'((TimeoutCycles == 0) ? 0 : (TimeoutCycles - 1));
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    // Clears the two byte-offset bits so APB only ever sees word addresses.
    localparam logic [AddrWidth-1:0] WordMask = ~{{(AddrWidth-2){1'b0}}, 2'b11};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   paddr_q, paddr_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [DataWidth-1:0]   pwdata_q, pwdata_d;
    logic [3:0]             pstrb_q, pstrb_d;
    logic                   rvalid_q, rvalid_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   gnt_s;

    // State, APB request and OBI response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            paddr_q   <= {AddrWidth{1'b0}};
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= {DataWidth{1'b0}};
            pstrb_q   <= 4'b0000;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DataWidth{1'b0}};
            err_q     <= 1'b0;
            cnt_q     <= {CntW{1'b0}};
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic; psel/penable/rvalid are computed for the *next* state
    // so that the APB and response outputs come straight from flops.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = {DataWidth{1'b0}};
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        gnt_s     = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_s = obi_req_i;
                if (obi_req_i) begin
                    paddr_d  = obi_addr_i & WordMask;
                    pwrite_d = obi_we_i;
                    pwdata_d = obi_wdata_i;
                    pstrb_d  = obi_we_i ? obi_be_i : 4'b0000;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end else begin
                    state_d  = IDLE;
                end
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = {CntW{1'b0}};
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    rvalid_d = 1'b1;
                    rdata_d  = pwrite_q ? {DataWidth{1'b0}} : prdata_i;
                    err_d    = pslverr_i;
                    state_d  = RESP;
                end else if ((TimeoutCycles != 32'd0) && (cnt_q == CntLast)) begin
                    // Peripheral hung: abandon the transfer with an error.
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                    state_d = ACCESS;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign obi_gnt_o    = gnt_s;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;
    assign paddr_o      = paddr_q;
    assign psel_o       = psel_q;
    assign penable_o    = penable_q;
    assign pwrite_o     = pwrite_q;
    assign pwdata_o     = pwdata_q;
    assign pstrb_o      = pstrb_q;
    assign pprot_o      = 3'b000;

endmodule

// File: tb/tb_zeroheti_obi_apb_bridge.sv
// Testbench for zeroheti_obi_apb_bridge (TimeoutCycles = 4).
module tb_zeroheti_obi_apb_bridge;

    localparam int TC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = 32'h0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready = 1'b0;
    logic [31:0] prdata = 32'h0;
    logic        pslverr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    zeroheti_obi_apb_bridge #(
        .AddrWidth(32), .DataWidth(32), .TimeoutCycles(TC)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_we_i(we),
        .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid),
        .obi_rdata_o(rdata), .obi_err_o(err),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
        .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;     // ACCESS cycles with PREADY low before PREADY
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] e_paddr;
        logic [3:0]  e_pstrb;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;     // cycle of rvalid, grant cycle = 0
        int          e_acc;     // number of ACCESS cycles
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference: what one OBI transaction should produce on both buses.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit   timed_out = (TC != 0) && (v.waits >= TC);
        r.e_paddr = v.addr - (v.addr % 32'd4);
        r.e_pstrb = v.we ? v.be : 4'h0;
        r.e_err   = timed_out ? 1'b1 : v.slverr;
        r.e_rdata = (timed_out || v.we) ? 32'h0 : v.prdata;
        r.e_acc   = timed_out ? TC : v.waits + 1;
        r.e_lat   = 2 + r.e_acc;
        return r;
    endfunction

    // Drive one transaction as manager and APB completer, checking both sides.
    task automatic run_txn(input vec_t v, input string tag);
        int cyc;
        int acc;
        bit done;
        bit stable_ok;
        @(negedge clk);
        req = 1'b1; addr = v.addr; we = v.we; be = v.be; wdata = v.wdata;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        #1;
        chk({tag, "_idle_outs"}, {28'h0, rvalid, err, psel, penable}, 32'h0);
        chk({tag, "_idle_rdata"}, rdata, 32'h0);
        chk({tag, "_gnt"}, {31'h0, gnt}, 32'h1);
        acc = 0; done = 1'b0; stable_ok = 1'b1;
        for (cyc = 1; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            req = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
            #1;
            if (gnt) stable_ok = 1'b0;
            if (rvalid) begin
                done = 1'b1;
                chk({tag, "_latency"}, cyc, v.e_lat);
                chk({tag, "_rdata"}, rdata, v.e_rdata);
                chk({tag, "_err"}, {31'h0, err}, {31'h0, v.e_err});
                chk({tag, "_psel_dropped"}, {30'h0, psel, penable}, 32'h0);
            end else if (psel) begin
                if (paddr !== v.e_paddr || pwrite !== v.we || pwdata !== v.wdata ||
                    pstrb !== v.e_pstrb || pprot !== 3'b000 || penable !== (cyc >= 2))
                    stable_ok = 1'b0;
                if (penable) begin
                    acc++;
                    if (acc > v.waits) begin
                        pready = 1'b1; prdata = v.prdata; pslverr = v.slverr;
                    end else begin
                        prdata = $urandom; pslverr = 1'($urandom);
                    end
                end
            end else begin
                stable_ok = 1'b0;
            end
        end
        if (!done) chk({tag, "_rvalid_seen"}, 32'h0, 32'h1);
        chk({tag, "_access_cycles"}, acc, v.e_acc);
        chk({tag, "_apb_stable"}, {31'h0, stable_ok}, 32'h1);
    endtask

    vec_t tbl[5];
    vec_t rv;
    logic [31:0] ba[3];
    logic [31:0] bd[3];
    int gq[$];
    int rq[$];
    int ng;
    int nr;
    bit leak;

    initial begin
        // Directed vectors with hand-computed expectations.
        tbl[0] = '{32'h0300_0006, 1'b0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0,
                   32'h0300_0004, 4'h0, 32'hDEAD_BEEF, 1'b0, 3, 1};
        tbl[1] = '{32'h0300_0010, 1'b1, 4'b0110, 32'h1234_5678, 3, 32'hA5A5_A5A5, 1'b0,
                   32'h0300_0010, 4'b0110, 32'h0, 1'b0, 6, 4};
        tbl[2] = '{32'h0300_0020, 1'b0, 4'h3, 32'h0, 0, 32'h1122_3344, 1'b1,
                   32'h0300_0020, 4'h0, 32'h1122_3344, 1'b1, 3, 1};
        tbl[3] = '{32'h0300_000B, 1'b0, 4'hF, 32'h5555_AAAA, 99, 32'hCAFE_F00D, 1'b0,
                   32'h0300_0008, 4'h0, 32'h0, 1'b1, 6, 4};
        tbl[4] = '{32'h0300_0103, 1'b1, 4'hF, 32'h0BAD_F00D, 1, 32'h7777_7777, 1'b1,
                   32'h0300_0100, 4'hF, 32'h0, 1'b1, 4, 2};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", {27'h0, psel, penable, pwrite, rvalid, err}, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_strb_prot", {25'h0, pstrb, pprot}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back reads with the request held high.
        ba[0] = 32'h0300_0040; ba[1] = 32'h0300_0045; ba[2] = 32'h0300_004A;
        bd[0] = 32'h1111_0001; bd[1] = 32'h2222_0002; bd[2] = 32'h3333_0003;
        ng = 0; nr = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            req = (ng < 3); addr = ba[(ng < 3) ? ng : 0]; we = 1'b0; be = 4'hF;
            pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
            #1;
            if (gnt) begin gq.push_back(cyc); ng++; end
            if (rvalid) begin
                if (nr < 3) chk($sformatf("b2b_rdata%0d", nr), rdata, bd[nr]);
                rq.push_back(cyc); nr++;
            end
            if (psel && penable && nr < 3) begin
                chk($sformatf("b2b_paddr%0d", nr), paddr, ba[nr] & 32'hFFFF_FFFC);
                pready = 1'b1; prdata = bd[nr];
            end
        end
        req = 1'b0;
        chk("b2b_grants", gq.size(), 3);
        chk("b2b_rvalids", rq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < gq.size()) chk($sformatf("b2b_gnt_cyc%0d", i), gq[i], 4 * i);
            if (i < rq.size()) chk($sformatf("b2b_rv_cyc%0d", i), rq[i], 4 * i + 3);
        end

        // Reset during an ACCESS wait state.
        @(negedge clk);
        req = 1'b1; addr = 32'h0300_0088; we = 1'b1; be = 4'hC; wdata = 32'hFEED_FACE;
        #1;
        chk("rstmid_gnt", {31'h0, gnt}, 32'h1);
        @(negedge clk); req = 1'b0;   // SETUP
        @(negedge clk);               // first ACCESS
        #1;
        chk("rstmid_in_access", {30'h0, psel, penable}, 32'h3);
        @(negedge clk);               // second ACCESS, PREADY still low
        rst = 1'b1;
        #1;
        chk("rstmid_ctrl", {27'h0, psel, penable, pwrite, rvalid, err}, 32'h0);
        chk("rstmid_paddr", paddr, 32'h0);
        chk("rstmid_pwdata", pwdata, 32'h0);
        chk("rstmid_strb_prot", {25'h0, pstrb, pprot}, 32'h0);
        chk("rstmid_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        leak = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (rvalid || psel) leak = 1'b1;
        end
        chk("rstmid_no_rvalid", {31'h0, leak}, 32'h0);
        run_txn(tbl[0], "post_rst");

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            rv.addr   = $urandom;
            rv.we     = 1'($urandom);
            rv.be     = 4'($urandom);
            rv.wdata  = $urandom;
            rv.waits  = $urandom_range(0, 6);
            rv.prdata = $urandom;
            rv.slverr = ($urandom_range(0, 3) == 0);
            run_txn(model(rv), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
